execute_stage: RTL

//  E stage of the 5-stage MIPS pipeline, directly downstream of the D stage. Consumes
//  the D/E register outputs (RD1/RD2/Ext, decoded ALU/MDU ops), applies M/W forwarding,

---
 rtl/execute_stage.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/execute_stage.sv
// E stage: operand forwarding, ALU, and a multi-cycle mult/div unit
// that owns the HI/LO registers.
module execute_stage #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  ALUOp_E_I,
  input  logic        BSel_E_I,
  input  logic [3:0]  MDOp_E_I,
  input  logic [1:0]  ForwardRs_E_I,
  input  logic [1:0]  ForwardRt_E_I,
  input  logic [31:0] RD1_E_I,
  input  logic [31:0] RD2_E_I,
  input  logic [31:0] Ext_E_I,
  input  logic [4:0]  Shamt_E_I,
  input  logic [31:0] MF_M_I,
  input  logic [31:0] MF_W_I,
  input  logic [2:0]  Tnew_E_I,
  output logic [31:0] ALUOut_E_O,
  output logic [31:0] WD_E_O,
  output logic [2:0]  Tnew_E_O,
  output logic        Start_E_O,
  output logic        Busy_E_O
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MFHI  = 4'd5;
  localparam logic [3:0] MD_MFLO  = 4'd6;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_op;
  logic [31:0]   r_a, r_b, r_hi, r_lo;

  logic [31:0] w_a, w_bt, w_b, w_alu;
  logic        w_start, w_busy;

  always_comb begin
    w_a = RD1_E_I;
    case (ForwardRs_E_I)
      2'b01:   w_a = MF_M_I;
      2'b10:   w_a = MF_W_I;
      default: w_a = RD1_E_I;
    endcase
  end

  always_comb begin
    w_bt = RD2_E_I;
    case (ForwardRt_E_I)
      2'b01:   w_bt = MF_M_I;
      2'b10:   w_bt = MF_W_I;
      default: w_bt = RD2_E_I;
    endcase
  end

  assign w_b    = BSel_E_I ? Ext_E_I : w_bt;
  assign WD_E_O = w_bt;

  always_comb begin
    w_alu = '0;
    case (ALUOp_E_I)
      4'd0:    w_alu = w_a + w_b;
      4'd1:    w_alu = w_a - w_b;
      4'd2:    w_alu = w_a & w_b;
      4'd3:    w_alu = w_a | w_b;
      4'd4:    w_alu = w_a ^ w_b;
      4'd5:    w_alu = ~(w_a | w_b);
      4'd6:    w_alu = {31'b0, $signed(w_a) < $signed(w_b)};
      4'd7:    w_alu = {31'b0, w_a < w_b};
      4'd8:    w_alu = w_b << Shamt_E_I;
      4'd9:    w_alu = w_b >> Shamt_E_I;
      4'd10:   w_alu = $signed(w_b) >>> Shamt_E_I;
      4'd11:   w_alu = w_b << w_a[4:0];
      4'd12:   w_alu = w_b >> w_a[4:0];
      4'd13:   w_alu = $signed(w_b) >>> w_a[4:0];
      4'd14:   w_alu = {w_b[15:0], 16'b0};
      default: w_alu = w_b;
    endcase
  end

  always_comb begin
    ALUOut_E_O = w_alu;
    if (MDOp_E_I == MD_MFHI) ALUOut_E_O = r_hi;
    else if (MDOp_E_I == MD_MFLO) ALUOut_E_O = r_lo;
  end

  assign Tnew_E_O = (Tnew_E_I == 3'd0) ? 3'd0 : Tnew_E_I - 3'd1;

  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_busy  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (MDOp_E_I >= MD_MULT && MDOp_E_I <= MD_DIVU) begin
          w_start = 1'b1;
          w_next  = S_BUSY;
        end
      end
      S_BUSY: begin
        w_busy = 1'b1;
        if (r_cnt == CW'(1)) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign Start_E_O = w_start;
  assign Busy_E_O  = w_busy;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Signed divide via magnitudes; 0x80000000 / -1 falls out as 0x80000000 r 0.
  logic        w_an, w_bn;
  logic [31:0] w_ua, w_ub, w_uq, w_ur, w_q, w_r;
  logic [63:0] w_ps, w_pu;

  assign w_an = (r_op == MD_DIV) && r_a[31];
  assign w_bn = (r_op == MD_DIV) && r_b[31];
  assign w_ua = w_an ? -r_a : r_a;
  assign w_ub = w_bn ? -r_b : r_b;
  assign w_uq = (w_ub == '0) ? '0 : w_ua / w_ub;
  assign w_ur = (w_ub == '0) ? '0 : w_ua % w_ub;
  assign w_q  = (w_an ^ w_bn) ? -w_uq : w_uq;
  assign w_r  = w_an ? -w_ur : w_ur;
  assign w_ps = {{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b};
  assign w_pu = {32'b0, r_a} * {32'b0, r_b};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_op  <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
    end else if (r_state == S_BUSY) begin
      r_cnt <= r_cnt - 1'b1;
      if (r_cnt == CW'(1)) begin
        case (r_op)
          MD_MULT:  {r_hi, r_lo} <= w_ps;
          MD_MULTU: {r_hi, r_lo} <= w_pu;
          MD_DIV, MD_DIVU: begin
            if (r_b != '0) begin
              r_lo <= w_q;
              r_hi <= w_r;
            end
          end
          default: ;
        endcase
      end
    end else if (w_start) begin
      r_a   <= w_a;
      r_b   <= w_bt;
      r_op  <= MDOp_E_I;
      r_cnt <= (MDOp_E_I <= MD_MULTU) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
    end else if (MDOp_E_I == MD_MTHI) begin
      r_hi <= w_a;
    end else if (MDOp_E_I == MD_MTLO) begin
      r_lo <= w_a;
    end
  end

endmodule
